reorder_buffer: RTL

//  In-order retirement buffer; the commit-side partner of the rename stage. Takes one rename_rob_t
//  per cycle at the tail, marks entries complete on execution writeback, retires the head in order.

---
 rtl/reorder_buffer_pkg.sv | 46 ++++
 rtl/reorder_buffer_rob_ptr.sv | 35 +++
 rtl/reorder_buffer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizes for the reorder buffer and its rename-stage partner.
// Entry, writeback and commit-rename bundles live here.
package reorder_buffer_pkg;

    localparam int ROB_ENTRY   = 32;
    localparam int ROB_IDX_W   = $clog2(ROB_ENTRY);
    localparam int ROB_CNT_W   = ROB_IDX_W + 1;
    localparam int WORD_SIZE_P = 16;
    localparam int FLAG_WIDTH  = 4;
    localparam int PREG_W      = 6;

    typedef struct packed {
        logic                   w_v;
        logic [PREG_W-1:0]      alloc_reg;
        logic [PREG_W-1:0]      freed_reg;
        logic                   is_store;
        logic                   is_spec;
        logic [WORD_SIZE_P-1:0] pc;
        logic [WORD_SIZE_P-1:0] predicted_pc;
        logic [FLAG_WIDTH-1:0]  flag_mask;
    } rename_rob_t;

    typedef struct packed {
        logic              w_v;
        logic [PREG_W-1:0] alloc_reg;
        logic [PREG_W-1:0] freed_reg;
    } commit_rename_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]   rob_idx;
        logic [WORD_SIZE_P-1:0] resolved_pc;
        logic [FLAG_WIDTH-1:0]  flags;
    } rob_wb_t;

    localparam int RENAME_ROB_ENTRY_WIDTH = $bits(rename_rob_t);
    localparam int COMMIT_RENAME_WIDTH    = $bits(commit_rename_t);

    function automatic logic [FLAG_WIDTH-1:0] merge_flags(
        input logic [FLAG_WIDTH-1:0] cur,
        input logic [FLAG_WIDTH-1:0] nxt,
        input logic [FLAG_WIDTH-1:0] mask
    );
        return (cur & ~mask) | (nxt & mask);
    endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping ROB index counter with increment and clear.
// Used for both head and tail pointers.
module rob_ptr #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with mispredict flush at commit.
// ROB_COMMIT_TRACE_EN adds commit_pc_o and retired_cnt_o.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  rename_rob_t            rename_rob_i,
    input  logic                   rename_rob_v_i,
    output logic                   rob_ready_o,
    output logic [ROB_IDX_W-1:0]   rob_num_o,
    input  logic                   wb_v_i,
    input  logic [ROB_IDX_W-1:0]   wb_rob_idx_i,
    input  logic [WORD_SIZE_P-1:0] wb_resolved_pc_i,
    input  logic [FLAG_WIDTH-1:0]  wb_flags_i,
    output logic                   commit_v_o,
    output commit_rename_t         commit_rename_o,
    output logic                   commit_store_v_o,
    output logic                   mispredict_o,
    output logic [WORD_SIZE_P-1:0] redirect_pc_o,
    output logic [FLAG_WIDTH-1:0]  arch_flags_o
`ifdef ROB_COMMIT_TRACE_EN
    ,
    output logic [WORD_SIZE_P-1:0] commit_pc_o,
    output logic [31:0]            retired_cnt_o
`endif
);

    logic [ROB_ENTRY-1:0]   alloc_q, alloc_d;
    logic [ROB_ENTRY-1:0]   done_q, done_d;
    rename_rob_t            ent_q [ROB_ENTRY];
    rename_rob_t            ent_d [ROB_ENTRY];
    logic [WORD_SIZE_P-1:0] rpc_q [ROB_ENTRY];
    logic [WORD_SIZE_P-1:0] rpc_d [ROB_ENTRY];
    logic [FLAG_WIDTH-1:0]  fl_q  [ROB_ENTRY];
    logic [FLAG_WIDTH-1:0]  fl_d  [ROB_ENTRY];
    logic [ROB_CNT_W-1:0]   count_q, count_d;
    logic                   pending_q, pending_d;
    logic                   mispredict_q, mispredict_d;
    logic [WORD_SIZE_P-1:0] redirect_q, redirect_d;
    logic [FLAG_WIDTH-1:0]  arch_flags_q, arch_flags_d;

    logic [ROB_IDX_W-1:0] head;
    logic [ROB_IDX_W-1:0] tail;
    logic                 do_alloc;
    logic                 do_commit;
    logic                 flush;
    rob_wb_t              wb;

    assign wb = '{rob_idx: wb_rob_idx_i,
                  resolved_pc: wb_resolved_pc_i,
                  flags: wb_flags_i};

    assign rob_ready_o = (count_q != ROB_CNT_W'(ROB_ENTRY)) && !mispredict_q;
    assign do_alloc    = rename_rob_v_i && rob_ready_o;
    assign do_commit   = alloc_q[head] && done_q[head]
                         && !pending_q && !mispredict_q;
    // The pending cycle is the last one before everything is wiped.
    assign flush       = pending_q;

    rob_ptr #(.W(ROB_IDX_W)) u_head (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (do_commit),
        .clr_i   (flush),
        .ptr_o   (head)
    );

    rob_ptr #(.W(ROB_IDX_W)) u_tail (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (do_alloc),
        .clr_i   (flush),
        .ptr_o   (tail)
    );

    always_comb begin
        alloc_d      = alloc_q;
        done_d       = done_q;
        ent_d        = ent_q;
        rpc_d        = rpc_q;
        fl_d         = fl_q;
        count_d      = count_q;
        pending_d    = pending_q;
        mispredict_d = pending_q;
        redirect_d   = redirect_q;
        arch_flags_d = arch_flags_q;

        if (wb_v_i && alloc_q[wb.rob_idx]) begin
            done_d[wb.rob_idx] = 1'b1;
            rpc_d[wb.rob_idx]  = wb.resolved_pc;
            fl_d[wb.rob_idx]   = wb.flags;
        end

        if (do_commit) begin
            alloc_d[head] = 1'b0;
            arch_flags_d  = merge_flags(arch_flags_q, fl_q[head],
                                        ent_q[head].flag_mask);
            if (ent_q[head].is_spec
                && rpc_q[head] != ent_q[head].predicted_pc) begin
                pending_d  = 1'b1;
                redirect_d = rpc_q[head];
            end
        end

        if (do_alloc) begin
            ent_d[tail]   = rename_rob_i;
            alloc_d[tail] = 1'b1;
            done_d[tail]  = 1'b0;
        end

        count_d = count_q + ROB_CNT_W'(do_alloc) - ROB_CNT_W'(do_commit);

        if (flush) begin
            alloc_d   = '0;
            done_d    = '0;
            count_d   = '0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            alloc_q      <= '0;
            done_q       <= '0;
            count_q      <= '0;
            pending_q    <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            arch_flags_q <= '0;
        end else begin
            alloc_q      <= alloc_d;
            done_q       <= done_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            arch_flags_q <= arch_flags_d;
        end
    end

    // Payload is qualified by alloc/done, so it needs no reset.
    always_ff @(posedge clk_i) begin
        ent_q <= ent_d;
        rpc_q <= rpc_d;
        fl_q  <= fl_d;
    end

    assign rob_num_o        = tail;
    assign commit_v_o       = do_commit;
    assign commit_store_v_o = do_commit && ent_q[head].is_store;
    assign mispredict_o     = mispredict_q;
    assign redirect_pc_o    = redirect_q;
    assign arch_flags_o     = arch_flags_q;

    assign commit_rename_o = '{w_v: ent_q[head].w_v,
                               alloc_reg: ent_q[head].alloc_reg,
                               freed_reg: ent_q[head].freed_reg};

`ifdef ROB_COMMIT_TRACE_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q + 32'(do_commit);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign commit_pc_o   = ent_q[head].pc;
    assign retired_cnt_o = retired_cnt_q;
`else
    logic unused_pc;
    assign unused_pc = ^ent_q[head].pc;
`endif

endmodule
